// File: rtl/alu_control_seq.sv
// Registered ALU control for the ID/EX boundary: decodes aluop/function into an
// extended ALU opcode and sequences multi-cycle MULT/DIV with a HI/LO stall.
module alu_control_seq #(
   parameter int ALU_OP_W = 5,
   parameter int AOP_W    = 4,
   parameter int MUL_LAT  = 4,
   parameter int DIV_LAT  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                valid_in,
   input  logic [5:0]          inst_function,
   input  logic [AOP_W-1:0]    control_aluop,
   input  logic                hold,
   input  logic                flush,
   output logic                ready_out,
   output logic [ALU_OP_W-1:0] alu_opcode,
   output logic                var_shift,
   output logic                illegal,
   output logic                valid_out,
   output logic                md_busy,
   output logic                md_done
);

   typedef enum logic [4:0] {
      OP_SLL  = 5'd0,  OP_SRL  = 5'd1,  OP_SRA  = 5'd2,  OP_ADD   = 5'd3,
      OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_XOR   = 5'd7,
      OP_NOR  = 5'd8,  OP_SLT  = 5'd9,  OP_LUI  = 5'd10, OP_ADDU  = 5'd11,
      OP_SUBU = 5'd12, OP_SLTU = 5'd13, OP_MFHI = 5'd14, OP_MFLO  = 5'd15,
      OP_MULT = 5'd16, OP_MULTU = 5'd17, OP_DIV = 5'd18, OP_DIVU  = 5'd19,
      OP_NOP  = 5'd31
   } alu_op_e;

   typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

   alu_op_e             dec_op;
   logic                dec_var;
   logic                dec_ill;
   logic                dec_hilo;
   logic                dec_mul;
   logic                dec_div;
   logic                accept;

   logic [ALU_OP_W-1:0] alu_opcode_d, alu_opcode_q;
   logic                var_shift_d, var_shift_q;
   logic                illegal_d, illegal_q;
   logic                valid_out_d, valid_out_q;
   md_state_e           state_d, state_q;
   logic [CNT_W-1:0]    cnt_d, cnt_q;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      dec_op  = OP_NOP;
      dec_var = 1'b0;
      dec_ill = 1'b0;
      case (control_aluop)
         AOP_W'(0): begin
            case (inst_function)
               6'b000000: dec_op = OP_SLL;
               6'b000010: dec_op = OP_SRL;
               6'b000011: dec_op = OP_SRA;
               6'b000100: begin dec_op = OP_SLL; dec_var = 1'b1; end
               6'b000110: begin dec_op = OP_SRL; dec_var = 1'b1; end
               6'b000111: begin dec_op = OP_SRA; dec_var = 1'b1; end
               6'b010000: dec_op = OP_MFHI;
               6'b010010: dec_op = OP_MFLO;
               6'b011000: dec_op = OP_MULT;
               6'b011001: dec_op = OP_MULTU;
               6'b011010: dec_op = OP_DIV;
               6'b011011: dec_op = OP_DIVU;
               6'b100000: dec_op = OP_ADD;
               6'b100001: dec_op = OP_ADDU;
               6'b100010: dec_op = OP_SUB;
               6'b100011: dec_op = OP_SUBU;
               6'b100100: dec_op = OP_AND;
               6'b100101: dec_op = OP_OR;
               6'b100110: dec_op = OP_XOR;
               6'b100111: dec_op = OP_NOR;
               6'b101010: dec_op = OP_SLT;
               6'b101011: dec_op = OP_SLTU;
               default:   dec_ill = 1'b1;
            endcase
         end
         AOP_W'(1): dec_op = OP_ADD;
         AOP_W'(2): dec_op = OP_AND;
         AOP_W'(3): dec_op = OP_OR;
         AOP_W'(4): dec_op = OP_XOR;
         AOP_W'(5): dec_op = OP_LUI;
         AOP_W'(6): dec_op = OP_SLT;
         AOP_W'(7): dec_op = OP_SUB;
         AOP_W'(8): dec_op = OP_ADDU;
         AOP_W'(9): dec_op = OP_SLTU;
         default:   dec_ill = 1'b1;
      endcase
   end

   assign dec_mul  = (dec_op == OP_MULT) || (dec_op == OP_MULTU);
   assign dec_div  = (dec_op == OP_DIV)  || (dec_op == OP_DIVU);
   assign dec_hilo = dec_mul || dec_div || (dec_op == OP_MFHI) || (dec_op == OP_MFLO);

   // HI/LO readers and new MULT/DIV wait until the sequencer is idle.
   assign ready_out = !hold && !(md_busy && dec_hilo);
   assign accept    = valid_in && ready_out && !flush;

   always_comb begin
      alu_opcode_d = alu_opcode_q;
      var_shift_d  = var_shift_q;
      illegal_d    = illegal_q;
      valid_out_d  = valid_out_q;
      if (!hold || flush) begin
         valid_out_d  = accept;
         alu_opcode_d = accept ? ALU_OP_W'(dec_op) : ALU_OP_W'(OP_NOP);
         var_shift_d  = accept && dec_var;
         illegal_d    = accept && dec_ill;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      md_busy = (state_q == MD_BUSY);
      md_done = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (accept && dec_mul) begin
               state_d = MD_BUSY;
               cnt_d   = MUL_INIT;
            end else if (accept && dec_div) begin
               state_d = MD_BUSY;
               cnt_d   = DIV_INIT;
            end
         end
         MD_BUSY: begin
            if (cnt_q == '0) begin
               md_done = 1'b1;
               state_d = MD_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_opcode_q <= ALU_OP_W'(OP_NOP);
         var_shift_q  <= 1'b0;
         illegal_q    <= 1'b0;
         valid_out_q  <= 1'b0;
         state_q      <= MD_IDLE;
         cnt_q        <= '0;
      end else begin
         alu_opcode_q <= alu_opcode_d;
         var_shift_q  <= var_shift_d;
         illegal_q    <= illegal_d;
         valid_out_q  <= valid_out_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
      end
   end

   assign alu_opcode = alu_opcode_q;
   assign var_shift  = var_shift_q;
   assign illegal    = illegal_q;
   assign valid_out  = valid_out_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode table sweep plus hand-written
// MULT/DIV, hold, flush and reset sequences.
module tb_alu_control_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       valid_in;
   logic [5:0] inst_function;
   logic [3:0] control_aluop;
   logic       hold;
   logic       flush;
   logic       ready_out;
   logic [4:0] alu_opcode;
   logic       var_shift;
   logic       illegal;
   logic       valid_out;
   logic       md_busy;
   logic       md_done;

   logic       ready_out1;
   logic [4:0] alu_opcode1;
   logic       var_shift1, illegal1, valid_out1, md_busy1, md_done1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_control_seq #(.ALU_OP_W(5), .AOP_W(4), .MUL_LAT(4), .DIV_LAT(32)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .inst_function(inst_function),
      .control_aluop(control_aluop), .hold(hold), .flush(flush), .ready_out(ready_out),
      .alu_opcode(alu_opcode), .var_shift(var_shift), .illegal(illegal),
      .valid_out(valid_out), .md_busy(md_busy), .md_done(md_done)
   );

   // Second instance exercises the single-cycle multiply corner.
   alu_control_seq #(.ALU_OP_W(5), .AOP_W(4), .MUL_LAT(1), .DIV_LAT(2)) dut1 (
      .clk(clk), .reset(reset), .valid_in(valid_in), .inst_function(inst_function),
      .control_aluop(control_aluop), .hold(hold), .flush(flush), .ready_out(ready_out1),
      .alu_opcode(alu_opcode1), .var_shift(var_shift1), .illegal(illegal1),
      .valid_out(valid_out1), .md_busy(md_busy1), .md_done(md_done1)
   );

   typedef struct {
      logic [5:0] fn;
      logic [3:0] aop;
      logic [4:0] op;
      logic       vs;
      logic       ill;
   } vec_t;

   vec_t vecs [35];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] fn, input logic [3:0] aop,
                        input logic h, input logic f);
      valid_in      = v;
      inst_function = fn;
      control_aluop = aop;
      hold          = h;
      flush         = f;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (md_busy && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) check("wait_idle_timeout", 32'(md_busy), 32'd0);
   endtask

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_MULT = 6'b011000;
   localparam logic [5:0] F_DIV  = 6'b011010;
   localparam logic [5:0] F_MFLO = 6'b010010;

   initial begin
      int busy_cnt, done_cnt;

      vecs[0]  = '{6'b000000, 4'd0, 5'd0,  1'b0, 1'b0};
      vecs[1]  = '{6'b000010, 4'd0, 5'd1,  1'b0, 1'b0};
      vecs[2]  = '{6'b000011, 4'd0, 5'd2,  1'b0, 1'b0};
      vecs[3]  = '{6'b000100, 4'd0, 5'd0,  1'b1, 1'b0};
      vecs[4]  = '{6'b000110, 4'd0, 5'd1,  1'b1, 1'b0};
      vecs[5]  = '{6'b000111, 4'd0, 5'd2,  1'b1, 1'b0};
      vecs[6]  = '{6'b010000, 4'd0, 5'd14, 1'b0, 1'b0};
      vecs[7]  = '{6'b010010, 4'd0, 5'd15, 1'b0, 1'b0};
      vecs[8]  = '{6'b011000, 4'd0, 5'd16, 1'b0, 1'b0};
      vecs[9]  = '{6'b011001, 4'd0, 5'd17, 1'b0, 1'b0};
      vecs[10] = '{6'b011010, 4'd0, 5'd18, 1'b0, 1'b0};
      vecs[11] = '{6'b011011, 4'd0, 5'd19, 1'b0, 1'b0};
      vecs[12] = '{6'b100000, 4'd0, 5'd3,  1'b0, 1'b0};
      vecs[13] = '{6'b100001, 4'd0, 5'd11, 1'b0, 1'b0};
      vecs[14] = '{6'b100010, 4'd0, 5'd4,  1'b0, 1'b0};
      vecs[15] = '{6'b100011, 4'd0, 5'd12, 1'b0, 1'b0};
      vecs[16] = '{6'b100100, 4'd0, 5'd5,  1'b0, 1'b0};
      vecs[17] = '{6'b100101, 4'd0, 5'd6,  1'b0, 1'b0};
      vecs[18] = '{6'b100110, 4'd0, 5'd7,  1'b0, 1'b0};
      vecs[19] = '{6'b100111, 4'd0, 5'd8,  1'b0, 1'b0};
      vecs[20] = '{6'b101010, 4'd0, 5'd9,  1'b0, 1'b0};
      vecs[21] = '{6'b101011, 4'd0, 5'd13, 1'b0, 1'b0};
      vecs[22] = '{6'b000101, 4'd0, 5'd31, 1'b0, 1'b1};
      vecs[23] = '{6'b100000, 4'd1, 5'd3,  1'b0, 1'b0};
      vecs[24] = '{6'b000000, 4'd2, 5'd5,  1'b0, 1'b0};
      vecs[25] = '{6'b100000, 4'd3, 5'd6,  1'b0, 1'b0};
      vecs[26] = '{6'b011000, 4'd4, 5'd7,  1'b0, 1'b0};
      vecs[27] = '{6'b100000, 4'd5, 5'd10, 1'b0, 1'b0};
      vecs[28] = '{6'b100000, 4'd6, 5'd9,  1'b0, 1'b0};
      vecs[29] = '{6'b100000, 4'd7, 5'd4,  1'b0, 1'b0};
      vecs[30] = '{6'b100000, 4'd8, 5'd11, 1'b0, 1'b0};
      vecs[31] = '{6'b100000, 4'd9, 5'd13, 1'b0, 1'b0};
      vecs[32] = '{6'b100000, 4'd12, 5'd31, 1'b0, 1'b1};
      vecs[33] = '{6'b100000, 4'd15, 5'd31, 1'b0, 1'b1};
      vecs[34] = '{6'b000111, 4'd0, 5'd2,  1'b1, 1'b0};

      // Reset values, observed before any clock edge.
      reset = 1'b1;
      drive(1'b0, 6'd0, 4'd0, 1'b0, 1'b0);
      #3;
      check("rst_opcode", 32'(alu_opcode), 32'd31);
      check("rst_var_shift", 32'(var_shift), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_valid_out", 32'(valid_out), 32'd0);
      check("rst_md_busy", 32'(md_busy), 32'd0);
      check("rst_md_done", 32'(md_done), 32'd0);
      tick();
      tick();
      reset = 1'b0;

      // First accept after release.
      drive(1'b1, F_ADD, 4'd1, 1'b0, 1'b0);
      #1;
      check("first_valid_before_edge", 32'(valid_out), 32'd0);
      tick();
      check("first_opcode", 32'(alu_opcode), 32'd3);
      check("first_valid", 32'(valid_out), 32'd1);

      // Reset mid-BUSY drops everything without a clock edge.
      drive(1'b1, F_MULT, 4'd0, 1'b0, 1'b0);
      tick();
      check("mid_busy_before_rst", 32'(md_busy), 32'd1);
      drive(1'b0, 6'd0, 4'd0, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 32'(md_busy), 32'd0);
      check("mid_rst_valid", 32'(valid_out), 32'd0);
      check("mid_rst_opcode", 32'(alu_opcode), 32'd31);
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_busy", 32'(md_busy), 32'd0);

      // Decode table sweep.
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].fn, vecs[i].aop, 1'b0, 1'b0);
         tick();
         check($sformatf("vec%0d_opcode", i), 32'(alu_opcode), 32'(vecs[i].op));
         check($sformatf("vec%0d_var_shift", i), 32'(var_shift), 32'(vecs[i].vs));
         check($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
         check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'd1);
         drive(1'b0, 6'd0, 4'd0, 1'b0, 1'b0);
         wait_idle();
      end
      tick();
      check("idle_valid", 32'(valid_out), 32'd0);
      check("idle_opcode", 32'(alu_opcode), 32'd31);

      // MULT, then an ADD that flows, then MFLO that waits for HI/LO.
      drive(1'b1, F_MULT, 4'd0, 1'b0, 1'b0);
      tick();
      check("mul_c1_busy", 32'(md_busy), 32'd1);
      check("mul_c1_done", 32'(md_done), 32'd0);
      check("mul1_c1_busy", 32'(md_busy1), 32'd1);
      check("mul1_c1_done", 32'(md_done1), 32'd1);
      drive(1'b1, F_ADD, 4'd1, 1'b0, 1'b0);
      #1;
      check("mul_add_ready", 32'(ready_out), 32'd1);
      tick();
      check("mul1_c2_busy", 32'(md_busy1), 32'd0);
      check("mul1_c2_done", 32'(md_done1), 32'd0);
      drive(1'b1, F_MFLO, 4'd0, 1'b0, 1'b0);
      for (int c = 2; c <= 6; c++) begin
         #1;
         check($sformatf("mul_c%0d_busy", c), 32'(md_busy), 32'(c <= 4));
         check($sformatf("mul_c%0d_done", c), 32'(md_done), 32'(c == 4));
         check($sformatf("mul_c%0d_ready", c), 32'(ready_out), 32'(c > 4));
         check($sformatf("mul_c%0d_valid", c), 32'(valid_out), 32'(c == 2 || c == 6));
         if (c == 2) check("mul_add_opcode", 32'(alu_opcode), 32'd3);
         if (c == 6) check("mul_mflo_opcode", 32'(alu_opcode), 32'd15);
         if (c == 6) drive(1'b0, 6'd0, 4'd0, 1'b0, 1'b0);
         tick();
      end

      // DIV runs its full latency even with a flush in the middle.
      drive(1'b1, F_DIV, 4'd0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 6'd0, 4'd0, 1'b0, 1'b0);
      busy_cnt = 0;
      done_cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         if (md_busy) busy_cnt++;
         if (md_done) done_cnt++;
         if (k == 5) drive(1'b1, F_ADD, 4'd1, 1'b0, 1'b1);
         tick();
         if (k == 5) begin
            check("div_flush_valid", 32'(valid_out), 32'd0);
            drive(1'b0, 6'd0, 4'd0, 1'b0, 1'b0);
         end
      end
      check("div_busy_cycles", 32'(busy_cnt), 32'd32);
      check("div_done_pulses", 32'(done_cnt), 32'd1);

      // Hold keeps a registered SUB; hold with flush inserts a bubble.
      drive(1'b1, F_ADD, 4'd7, 1'b0, 1'b0);
      tick();
      check("hold_sub_opcode", 32'(alu_opcode), 32'd4);
      drive(1'b1, F_ADD, 4'd2, 1'b1, 1'b0);
      for (int h = 0; h < 3; h++) begin
         #1;
         check($sformatf("hold%0d_ready", h), 32'(ready_out), 32'd0);
         tick();
         check($sformatf("hold%0d_opcode", h), 32'(alu_opcode), 32'd4);
         check($sformatf("hold%0d_valid", h), 32'(valid_out), 32'd1);
      end
      drive(1'b1, F_ADD, 4'd2, 1'b1, 1'b1);
      tick();
      check("hold_flush_valid", 32'(valid_out), 32'd0);
      check("hold_flush_opcode", 32'(alu_opcode), 32'd31);

      // Flushed MULT never starts the sequencer.
      drive(1'b1, F_MULT, 4'd0, 1'b0, 1'b1);
      tick();
      check("flush_mult_busy", 32'(md_busy), 32'd0);
      check("flush_mult_valid", 32'(valid_out), 32'd0);
      drive(1'b0, 6'd0, 4'd0, 1'b0, 1'b0);
      tick();
      check("flush_mult_busy2", 32'(md_busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
